// File: rtl/kv_filter_db.sv
// kv_filter_db: flow-state key/value table serving the DNS-filter parser.
// Direct-mapped table of 2^ADDR_W entries {valid, key, status} indexed by an
// XOR-folded hash of the key. One request is processed at a time:
// IDLE -> RD -> CMP -> RSP. The table is cleared by a sweep after every reset.
//
// Ports:
//   clk156     single clock, all logic on posedge
//   eth_rst_n  asynchronous active-low reset
//   in_key     request key
//   in_flag    [0]=request enable, [2:1]=op, [3]=reserved
//   in_valid   one-cycle request strobe
//   out_valid  one-cycle reply strobe
//   out_flag   [0]=hit, [2:1]=entry status after op, [3]=evicted
//   busy       high during the clear sweep or while a request is in flight
//   drop_cnt   saturating count of requests lost while busy
//   debug      {state[1:0], 2'b0, entry_valid_cnt[3:0]}
module kv_filter_db #(
  parameter int unsigned KEY_SIZE = 96,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                clk156,
  input  logic                eth_rst_n,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [3:0]          in_flag,
  input  logic                in_valid,
  output logic                out_valid,
  output logic [3:0]          out_flag,
  output logic                busy,
  output logic [15:0]         drop_cnt,
  output logic [7:0]          debug
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam int unsigned NSlice  = (KEY_SIZE + ADDR_W - 1) / ADDR_W;
  localparam int unsigned ExtW    = NSlice * ADDR_W;
  localparam int unsigned EntryW  = KEY_SIZE + 3;
  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    StInit = 3'd0,
    StIdle = 3'd1,
    StRd   = 3'd2,
    StCmp  = 3'd3,
    StRsp  = 3'd4
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [KEY_SIZE-1:0] r_key, w_key_nxt;
  logic [1:0]          r_op, w_op_nxt;
  logic [3:0]          r_out_flag, w_flag_nxt;
  logic [15:0]         r_drop_cnt, w_drop_nxt;
  logic [3:0]          r_vcnt, w_vcnt_nxt;

  logic [EntryW-1:0]   r_mem [Depth];
  logic [EntryW-1:0]   r_rd_data;
  logic                w_we;
  logic [EntryW-1:0]   w_wdata;

  logic [ExtW-1:0]     w_key_ext;
  logic [ADDR_W-1:0]   w_hash;
  logic                w_rd_valid, w_hit;
  logic [KEY_SIZE-1:0] w_rd_key;
  logic [1:0]          w_rd_st;
  logic                w_unused_flag;

  assign w_unused_flag = in_flag[3];

  // Zero-extend the key to whole slices, then XOR-fold down to an address.
  always_comb begin
    w_key_ext = ExtW'(in_key);
    w_hash    = '0;
    for (int i = 0; i < NSlice; i++) begin
      w_hash = w_hash ^ w_key_ext[i*ADDR_W +: ADDR_W];
    end
  end

  assign w_rd_valid = r_rd_data[EntryW-1];
  assign w_rd_key   = r_rd_data[KEY_SIZE+1:2];
  assign w_rd_st    = r_rd_data[1:0];
  assign w_hit      = w_rd_valid && (w_rd_key == r_key);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_key_nxt   = r_key;
    w_op_nxt    = r_op;
    w_flag_nxt  = r_out_flag;
    w_vcnt_nxt  = r_vcnt;
    w_we        = 1'b0;
    w_wdata     = '0;
    unique case (r_state)
      StInit: begin
        w_we       = 1'b1;
        w_addr_nxt = r_addr + ADDR_W'(1);
        if (r_addr == LastAddr) w_state_nxt = StIdle;
      end
      StIdle: begin
        if (in_valid && in_flag[0]) begin
          w_key_nxt   = in_key;
          w_op_nxt    = in_flag[2:1];
          w_addr_nxt  = w_hash;
          w_state_nxt = StRd;
        end
      end
      StRd: w_state_nxt = StCmp;
      StCmp: begin
        w_state_nxt = StRsp;
        case (r_op)
          2'b01: begin // SUSPECT: insert or report existing status
            if (w_hit) begin
              w_flag_nxt = {1'b0, w_rd_st, 1'b1};
            end else begin
              w_we       = 1'b1;
              w_wdata    = {1'b1, r_key, 2'b01};
              w_flag_nxt = {w_rd_valid, 2'b01, 1'b0};
              if (!w_rd_valid && (r_vcnt != 4'hF)) w_vcnt_nxt = r_vcnt + 4'd1;
            end
          end
          2'b10: begin // ARREST
            if (w_hit) begin
              w_we       = 1'b1;
              w_wdata    = {1'b1, r_key, 2'b10};
              w_flag_nxt = 4'b0101;
            end else begin
              w_flag_nxt = 4'b0000;
            end
          end
          2'b11: w_flag_nxt = w_hit ? {1'b0, w_rd_st, 1'b1} : 4'b0000; // LOOKUP
          default: begin // DELETE
            if (w_hit) begin
              w_we       = 1'b1;
              w_flag_nxt = 4'b0001;
              if (r_vcnt != 4'h0) w_vcnt_nxt = r_vcnt - 4'd1;
            end else begin
              w_flag_nxt = 4'b0000;
            end
          end
        endcase
      end
      StRsp:   w_state_nxt = StIdle;
      default: w_state_nxt = StInit;
    endcase
  end

  // Every enabled request outside IDLE (including RSP and the sweep) is lost.
  always_comb begin
    w_drop_nxt = r_drop_cnt;
    if (in_valid && in_flag[0] && (r_state != StIdle) && (r_drop_cnt != 16'hFFFF)) begin
      w_drop_nxt = r_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      r_state    <= StInit;
      r_addr     <= '0;
      r_key      <= '0;
      r_op       <= '0;
      r_out_flag <= '0;
      r_drop_cnt <= '0;
      r_vcnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_key      <= w_key_nxt;
      r_op       <= w_op_nxt;
      r_out_flag <= w_flag_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_vcnt     <= w_vcnt_nxt;
    end
  end

  // Table storage: synchronous read in RD, single write port shared by sweep and CMP.
  always_ff @(posedge clk156) begin
    if (w_we) r_mem[r_addr] <= w_wdata;
    if (r_state == StRd) r_rd_data <= r_mem[r_addr];
  end

  assign out_valid = (r_state == StRsp);
  assign out_flag  = r_out_flag;
  assign busy      = (r_state != StIdle);
  assign drop_cnt  = r_drop_cnt;
  assign debug     = {r_state[1:0], 2'b00, r_vcnt};

endmodule

// File: tb/tb_kv_filter_db.sv
// Directed self-checking bench for kv_filter_db.
module tb_kv_filter_db;

  logic        clk156 = 1'b0;
  logic        eth_rst_n;
  logic [95:0] in_key;
  logic [3:0]  in_flag;
  logic        in_valid;
  logic        out_valid;
  logic [3:0]  out_flag;
  logic        busy;
  logic [15:0] drop_cnt;
  logic [7:0]  debug;

  int n_vec;
  int n_err;

  // hash(K1) == hash(K2) == 8'h36, hash(K3) == 8'h37
  localparam logic [95:0] K1 = 96'h0A000001_0A000002_0035_0000;
  localparam logic [95:0] K2 = 96'h0A000002_0A000001_0035_0000;
  localparam logic [95:0] K3 = 96'h0B000001_0A000002_0035_0000;

  kv_filter_db #(.KEY_SIZE(96), .ADDR_W(8)) dut (
    .clk156   (clk156),
    .eth_rst_n(eth_rst_n),
    .in_key   (in_key),
    .in_flag  (in_flag),
    .in_valid (in_valid),
    .out_valid(out_valid),
    .out_flag (out_flag),
    .busy     (busy),
    .drop_cnt (drop_cnt),
    .debug    (debug)
  );

  always #5 clk156 = ~clk156;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  // Issue one request from IDLE; check reply timing (only at N+3) and flag.
  task automatic req(input string tag, input logic [95:0] key, input logic [3:0] flag,
                     input logic [3:0] exp);
    logic [2:0] seen;
    logic [3:0] flg;
    in_key   = key;
    in_flag  = flag;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen[0]  = out_valid;
    tick();
    seen[1]  = out_valid;
    tick();
    seen[2]  = out_valid;
    flg      = out_flag;
    tick();
    chk({tag, "_lat"}, 32'(seen), 32'(3'b100));
    chk(tag, 32'(flg), 32'(exp));
  endtask

  initial begin
    logic ov;
    int   cyc;
    n_vec     = 0;
    n_err     = 0;
    eth_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_key    = '0;
    in_flag   = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_oflag", 32'(out_flag), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_debug", 32'(debug), 32'd0);

    // Sweep: busy for 255 cycles, free at 256; request at cycle 10 dropped
    @(negedge clk156);
    eth_rst_n = 1'b1;
    ov = 1'b0;
    for (int c = 1; c <= 256; c++) begin
      tick();
      ov = ov | out_valid;
      if (c == 9) begin
        in_key   = K1;
        in_flag  = 4'b0011;
        in_valid = 1'b1;
      end
      if (c == 10) in_valid = 1'b0;
      if (c == 255) chk("init_busy255", 32'(busy), 32'd1);
      if (c == 256) chk("init_busy256", 32'(busy), 32'd0);
    end
    chk("init_drop", 32'(drop_cnt), 32'd1);
    chk("init_noreply", 32'(ov), 32'd0);
    chk("idle_debug", 32'(debug), 32'h40);

    // Insert, repeat, arrest, blocked re-suspect
    req("ins_k1", K1, 4'b0011, 4'b0010);
    chk("ins_debug", 32'(debug), 32'h41);
    req("ins_k1_again", K1, 4'b0011, 4'b0011);
    chk("flag_hold", 32'(out_flag), 32'h3);
    req("arrest_k1", K1, 4'b0101, 4'b0101);
    req("susp_arrested", K1, 4'b0011, 4'b0101);

    // Collision eviction
    req("collide_k2", K2, 4'b0011, 4'b1010);
    chk("evict_debug", 32'(debug), 32'h41);
    req("lookup_k1_gone", K1, 4'b0111, 4'b0000);
    req("lookup_k2", K2, 4'b0111, 4'b0011);

    // Delete, miss cases, reserved bit ignored
    req("delete_k2", K2, 4'b0001, 4'b0001);
    chk("del_debug", 32'(debug), 32'h40);
    req("lookup_k2_gone", K2, 4'b0111, 4'b0000);
    req("delete_miss", K3, 4'b0001, 4'b0000);
    chk("del_floor_debug", 32'(debug), 32'h40);
    req("arrest_miss", K3, 4'b0101, 4'b0000);
    req("ins_k3_rsvd", K3, 4'b1011, 4'b0010);

    // in_valid without enable: ignored, not counted
    in_key   = K1;
    in_flag  = 4'b0010;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ov = 1'b0;
    repeat (4) begin
      tick();
      ov = ov | out_valid;
    end
    chk("ignored_noreply", 32'(ov), 32'd0);
    chk("ignored_nodrop", 32'(drop_cnt), 32'd1);

    // Back-to-back requests: second dropped, exactly one reply
    in_key   = K3;
    in_flag  = 4'b0111;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    cyc = 0;
    repeat (5) begin
      if (out_valid) begin
        cyc++;
        chk("b2b_flag", 32'(out_flag), 32'h3);
      end
      tick();
    end
    chk("b2b_replies", 32'(cyc), 32'd1);
    chk("b2b_drop", 32'(drop_cnt), 32'd2);

    // Continuous stream: 3 drops per 4 cycles -> 66000 drops, saturates
    in_key   = K3;
    in_flag  = 4'b0111;
    in_valid = 1'b1;
    repeat (88000) @(posedge clk156);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 8) begin
      tick();
      cyc++;
    end
    chk("sat_idle", 32'(busy), 32'd0);
    chk("sat_drop", 32'(drop_cnt), 32'hFFFF);

    // Reset while in CMP aborts the request and re-sweeps the table
    req("ins_k1_pre_rst", K1, 4'b0011, 4'b0010);
    in_key   = K1;
    in_flag  = 4'b0111;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("in_cmp_debug", 32'(debug), 32'hC2);
    eth_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_debug", 32'(debug), 32'd0);
    ov = out_valid;
    repeat (2) begin
      tick();
      ov = ov | out_valid;
    end
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    chk("mid_rst_oflag", 32'(out_flag), 32'd0);
    @(negedge clk156);
    eth_rst_n = 1'b1;
    cyc = 0;
    while (busy && cyc < 300) begin
      tick();
      ov = ov | out_valid;
      cyc++;
    end
    chk("resweep_cycles", 32'(cyc), 32'd256);
    chk("mid_rst_noreply", 32'(ov), 32'd0);
    req("k1_after_rst", K1, 4'b0111, 4'b0000);
    req("k3_after_rst", K3, 4'b0111, 4'b0000);
    chk("post_rst_debug", 32'(debug), 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
